// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// launch FSM state type used by uart_tx_fifo.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } uart_txf_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer / serializer signal bundle for uart_tx_fifo. The level signal
// exists only when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  logic                              wr_en;
  logic [uart_pkg::UART_DATA_W-1:0]  wr_data;
  logic                              full;
  logic                              empty;
  logic                              overflow;
  logic                              start;
  logic [uart_pkg::UART_DATA_W-1:0]  data;
  logic                              idle_ready;
`ifdef UART_TX_FIFO_LEVEL_EN
  localparam int LVL_W = $clog2(DEPTH + 1);
  logic [LVL_W-1:0]                  level;

  modport master (
    output wr_en, wr_data, idle_ready,
    input  full, empty, overflow, start, data, level
  );

  modport slave (
    input  wr_en, wr_data, idle_ready,
    output full, empty, overflow, start, data, level
  );
`else
  modport master (
    output wr_en, wr_data, idle_ready,
    input  full, empty, overflow, start, data
  );

  modport slave (
    input  wr_en, wr_data, idle_ready,
    output full, empty, overflow, start, data
  );
`endif

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x byte register array for uart_tx_fifo: one synchronous write port,
// one asynchronous read port. Contents are not reset; the pointers are.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO that drains into uart_tx one byte at a time via start/data/idle_ready.
// Define UART_TX_FIFO_LEVEL_EN to expose the occupancy count on bus.level.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle serializer
// LAUNCH    | start pulse; data register was just loaded by the pop
// WAIT_BUSY | waiting for idle_ready to fall, bounded by BUSY_WAIT cycles
// WAIT_DONE | serializer busy; waiting for idle_ready to rise
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 8
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(BUSY_WAIT + 1);

  uart_txf_state_t        state, state_nxt;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [WW-1:0]          wait_cnt, wait_cnt_nxt;
  logic [UART_DATA_W-1:0] data_q, rd_byte;
  logic                   overflow_q;
  logic                   full, empty, pop, push, start;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the head entry on the same edge, so a full FIFO can still accept.
  assign push  = bus.wr_en && (!full || pop);

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pop          = 1'b0;
    start        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && bus.idle_ready) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        start        = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.idle_ready) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
          // Serializer never acknowledged; the byte is considered sent.
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.idle_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        data_q <= rd_byte;
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (bus.wr_en && !push) overflow_q <= 1'b1;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.start    = start;
  assign bus.data     = data_q;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level    = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes queue expected bytes, a monitor
// checks every start pulse, data stability and occupancy flags each cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int BUSY_WAIT = 8;

  logic clk;
  logic rst;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int push_acc = 0;
  int pop_cnt = 0;
  int lvl_base = 0;
  int start_count = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int prev_start_cyc = 0;

  logic stub_en = 1'b0;
  logic stub_ir = 1'b1;
  logic man_ir = 1'b1;
  int stub_len = 3;

  assign bus.idle_ready = stub_en ? stub_ir : man_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that samples the push.
  task automatic push_byte(input logic [7:0] b, input bit acc);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(b);
      push_acc++;
    end
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int max_cyc, input string name);
    int w;
    w = 0;
    while (start_count < target && w < max_cyc) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk(name, start_count, target);
  endtask

  // uart_tx stand-in: drops idle_ready on start and holds it low stub_len cycles.
  initial begin
    int busy;
    busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!stub_en) begin
        busy = 0;
        stub_ir = 1'b1;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) stub_ir = 1'b1;
      end else if (bus.start) begin
        stub_ir = 1'b0;
        busy = stub_len;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_start;
    logic [7:0] prev_data;
    int         ir_run;
    int         model;
    prev_start = 1'b0;
    prev_data = 8'h00;
    ir_run = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_start = 1'b0;
        prev_data = 8'h00;
        ir_run = 0;
        continue;
      end
      if (bus.start) begin
        pop_cnt++;
        start_count++;
        prev_start_cyc = last_start_cyc;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) chk("start_unexpected", 32'(bus.data), 32'hFFFF_FFFF);
        else chk("start_data", 32'(bus.data), 32'(exp_q.pop_front()));
        chk("start_width", 32'(prev_start), 32'd0);
        if (stub_en) chk("ir_gap_ge2", 32'(ir_run >= 2), 32'd1);
      end else begin
        chk("data_hold", 32'(bus.data), 32'(prev_data));
      end
      model = push_acc - pop_cnt - lvl_base;
      chk("empty_flag", 32'(bus.empty), 32'(model == 0));
      chk("full_flag", 32'(bus.full), 32'(model == DEPTH));
`ifdef UART_TX_FIFO_LEVEL_EN
      chk("level", 32'(bus.level), 32'(model));
`endif
      ir_run = bus.idle_ready ? ir_run + 1 : 0;
      prev_start = bus.start;
      prev_data = bus.data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int w;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    rst = 1'b0;
    #2;
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_data", 32'(bus.data), 32'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stub_len = 3;
    stub_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte latency: push at edge N, start during the cycle after N+1.
    sc = start_count;
    push_byte(8'h41, 1'b1);
    @(negedge clk);
    chk("lat_empty_after_push", 32'(bus.empty), 32'd0);
    chk("lat_no_start_yet", 32'(bus.start), 32'd0);
    @(negedge clk);
    chk("lat_start_high", 32'(bus.start), 32'd1);
    chk("lat_data", 32'(bus.data), 32'h41);
    @(negedge clk);
    chk("lat_start_low", 32'(bus.start), 32'd0);
    wait_starts(sc + 1, 20, "single_done");
    repeat (10) @(posedge clk);
    #1;

    // Burst of three.
    sc = start_count;
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    wait_starts(sc + 3, 100, "burst_done");
    repeat (10) @(posedge clk);
    #1;

    // Busy timeout: idle_ready stuck high.
    stub_en = 1'b0;
    man_ir = 1'b1;
    sc = start_count;
    push_byte(8'h55, 1'b1);
    push_byte(8'hAA, 1'b1);
    wait_starts(sc + 2, 60, "timeout_done");
    chk("timeout_spacing", 32'(last_start_cyc - prev_start_cyc), 32'(BUSY_WAIT + 2));
    repeat (BUSY_WAIT + 5) @(posedge clk);
    #1;

    // Fill to full with the serializer busy, then push+pop, then overflow.
    man_ir = 1'b0;
    sc = start_count;
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'h80 + i;
      push_byte(w[7:0], 1'b1);
      if (i == DEPTH - 2) chk("not_full_before_last", 32'(bus.full), 32'd0);
    end
    chk("full_after_depth", 32'(bus.full), 32'd1);
    chk("no_overflow_at_full", 32'(bus.overflow), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h99;
    man_ir = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h99);
    push_acc++;
    #1;
    bus.wr_en = 1'b0;
    man_ir = 1'b0;
    chk("pushpop_no_overflow", 32'(bus.overflow), 32'd0);
    chk("pushpop_still_full", 32'(bus.full), 32'd1);
    push_byte(8'hEE, 1'b0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    chk("overflow_full", 32'(bus.full), 32'd1);
    stub_en = 1'b1;
    wait_starts(sc + DEPTH + 1, 400, "full_drain");
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of a stream.
    sc = start_count;
    for (int i = 0; i < 5; i++) begin
      w = 8'hC0 + i;
      push_byte(w[7:0], 1'b1);
    end
    wait_starts(sc + 2, 60, "pre_reset");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_start", 32'(bus.start), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_full", 32'(bus.full), 32'd0);
    chk("midrst_data", 32'(bus.data), 32'h00);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("midrst_level", 32'(bus.level), 32'd0);
`endif
    exp_q.delete();
    lvl_base = push_acc - pop_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sc = start_count;
    repeat (20) @(posedge clk);
    #1;
    chk("no_start_after_reset", 32'(start_count), 32'(sc));
    chk("empty_after_reset", 32'(bus.empty), 32'd1);

    // Wrap-around: 3*DEPTH bytes through the pointers.
    stub_len = 2;
    sc = start_count;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      w = 0;
      while ((push_acc - pop_cnt - lvl_base) >= DEPTH && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      push_byte(i[7:0], 1'b1);
    end
    wait_starts(sc + 3 * DEPTH, 1000, "wrap_done");
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of `uart_tx`. Producers push bytes at any rate up to one per clock. The block drains them one at a time into `uart_tx` through its `start`/`data`/`idle_ready` handshake, so software-facing logic never has to poll the serializer. Output ports connect 1:1 to `uart_tx` inputs of the same name.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2.
- `BUSY_WAIT`, 8, max cycles to wait for `idle_ready` to fall after a `start` pulse.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  push request.
- `wr_data`  in  8  byte to push.
- `full`  out  1  no free entry.
- `empty`  out  1  no stored entry.
- `overflow`  out  1  sticky: a push was dropped.
- `start`  out  1  one-cycle launch pulse to `uart_tx`.
- `data`  out  8  byte to `uart_tx`; stable from the `start` cycle until the byte completes.
- `idle_ready`  in  1  from `uart_tx`; high when the serializer is idle.
- `level`  out  $clog2(DEPTH+1)  occupancy; only present with `UART_TX_FIFO_LEVEL_EN`.

## Operation
- Storage is a circular buffer with read/write pointers of width $clog2(DEPTH); pointers wrap from DEPTH-1 to 0.
- Occupancy is tracked by a count of width $clog2(DEPTH+1).
- Push accepted when `wr_en && (!full || pop)` in the same cycle. A push and a pop in the same cycle leave the count unchanged.
- Push with `full` and no pop: the byte is dropped and `overflow` is set to 1. It is cleared only by reset.
- Launch FSM states are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
  - IDLE: if `!empty && idle_ready`, pop the head into the `data` register, go to LAUNCH.
  - LAUNCH: `start`=1 for exactly this cycle, clear the wait counter, go to WAIT_BUSY.
  - WAIT_BUSY: on `idle_ready`=0 go to WAIT_DONE. If the counter reaches BUSY_WAIT, go to IDLE (the byte is treated as sent; no retry).
  - WAIT_DONE: on `idle_ready`=1 go to IDLE.
- `data` holds its value outside LAUNCH and changes only on a pop.
- Pop occurs only in the IDLE→LAUNCH transition, so there is at most one byte in flight.

## Timing
- Reset (async assert, sync release) sets:
  - `start`=0, `data`=8'h00, `full`=0, `empty`=1, `overflow`=0, `level`=0;
  - both pointers to 0, FSM to IDLE.
- Reset asserted mid-transmission:
  - the in-flight byte and all queued bytes are discarded;
  - `start` never glitches high.
- `full`/`empty`/`level` are registered and reflect the count after the edge that updates it.
- Latency: with the FIFO empty, FSM in IDLE and `idle_ready`=1, a push accepted at edge N gives:
  - `empty`=0 after N;
  - the pop at edge N+1;
  - `start`=1 and `data` valid during the cycle after N+1;
  - `start` falls after edge N+2.
- Back-to-back bytes: the next `start` comes no earlier than 2 cycles after `idle_ready` rises.
- `idle_ready` falling in the same cycle as `start` is legal. WAIT_BUSY samples it on the following edge, so `uart_tx` must hold it low for at least one cycle after `start`.

## Configuration
- `UART_TX_FIFO_LEVEL_EN` defined: the `level` port exists and mirrors the internal count.
- Not defined: the port is absent. The internal count still exists to derive `full`/`empty`.
- Behaviour is otherwise identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state typedef (`uart_txf_state_t`: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - byte width constant `UART_DATA_W`=8.
- One sub-module, `uart_fifo_mem`: DEPTH×8 register array with write port (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`).
- Pointers, count and FSM live in the top.

## Test plan
- Reset: assert `rst`=0 mid-stream → `start`=0, `empty`=1, `data`=8'h00, `overflow`=0 immediately. After release, no `start` until a new push.
- Single byte: push 8'h41 with `idle_ready`=1 → `start` high exactly one cycle, 2 cycles after the push edge, with `data`=8'h41. Full loop through `uart_tx`→`uart_rx` yields `data_ready` with 8'h41.
- Burst: push 8'h41, 8'h42, 8'h43 on consecutive cycles → three `start` pulses, each only after `idle_ready` has fallen and risen again. `data` stays constant during each byte; `uart_rx` sees the bytes in order.
- Full/overflow: with `idle_ready` held 0, push DEPTH+1 bytes → `full`=1 after the DEPTH-th push, the last byte is dropped, `overflow`=1. A push plus pop on the same full cycle is accepted without setting `overflow`.
- Busy timeout: `idle_ready` held 1 (stub) → after `start`, FSM returns to IDLE BUSY_WAIT cycles later, then launches the next queued byte.
- Wrap-around: push and drain 3×DEPTH bytes 8'h00..8'h2F → output order preserved across pointer wrap. With `UART_TX_FIFO_LEVEL_EN`, `level` tracks the count exactly every cycle.
